ddr_tx_serializer: RTL and testbench
====================================

# ddr_tx_serializer

Parallel-to-DDR serializer and sequencer for the wave generator's output pins. It accepts WIDTH-bit sample words over a valid/ready handshake and emits them two bits per clock, MSB first, as rise/fall bit pairs. The parent drives those pairs straight into an `out_ddr_flop` instance and sends `frame` through a second instance. The block holds the pins at a defined idle level between words, streams back-to-back words with no gap, and flags underruns.

## Interface
- `WIDTH`, 8: bits per word. Must be even and ≥ 2. Let P = WIDTH/2 pairs per word.
- `IDLE_BIT`, 1'b0: level driven on `d_rise`/`d_fall` when no word is being shifted.
- `clk` in 1: the single clock, also the DDR flop clock.
- `rst` in 1: reset, synchronous to `clk`, active-high.
- `enable` in 1: permits acceptance of new words.
- `s_data` in WIDTH: word to serialize.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: block accepts the word on this edge if `s_valid` is high.
- `d_rise` out 1: bit for the rising half of the cycle, to `out_ddr_flop.d_rise`.
- `d_fall` out 1: bit for the falling half of the cycle, to `out_ddr_flop.d_fall`.
- `frame` out 1: high during the first pair of each word.
- `busy` out 1: a word is being shifted.
- `underrun` out 1: one-cycle pulse when a stream ends without a following word.

## Operation
- **State.** FSM states are IDLE and SHIFT.
- **Registers.** Shift register `sr[WIDTH-1:0]`, pair counter `cnt` (0..P-1, width clog2(P), minimum 1), and state.
- **Handshake.** `s_ready = enable && (state==IDLE || cnt==P-1)`. It depends on registered state and `enable` only, never on `s_valid`. Accept = `s_valid && s_ready`.
- **IDLE.**
  - On accept: `sr <= s_data`, `cnt <= 0`, go to SHIFT.
  - Otherwise remain in IDLE.
- **SHIFT, `cnt < P-1`:** `sr <= sr << 2`, `cnt <= cnt+1`.
- **SHIFT, `cnt == P-1`:**
  - On accept: load as in IDLE and stay in SHIFT, giving a gapless stream.
  - Otherwise go to IDLE and pulse `underrun` for one cycle.
- **Outputs.** All are decoded from registers only:
  - `d_rise = SHIFT ? sr[WIDTH-1] : IDLE_BIT`
  - `d_fall = SHIFT ? sr[WIDTH-2] : IDLE_BIT`
  - `frame = SHIFT && cnt==0`
  - `busy = SHIFT`
- **`underrun`** is a registered pulse asserted on the edge of the SHIFT→IDLE transition. This transition fires whether the cause is `s_valid` low or `enable` low.
- **`enable` deasserted mid-word:** the current word completes and no further word is accepted.
- **WIDTH=2:** `cnt` stays 0. Every SHIFT cycle is both the first and the last pair, so `frame` is high on every shifted cycle.
- **Reset** (`rst` high at an edge) forces:
  - state = IDLE, `sr` = 0, `cnt` = 0, `underrun` = 0.
  - On the following cycle: `d_rise = d_fall = IDLE_BIT`, `frame = 0`, `busy = 0`, `s_ready = enable`.
  - Reset mid-word aborts the word immediately and does not pulse `underrun`.
  - `rst` takes priority over accept.

## Timing
- **Latency.** For a word accepted at edge k, pair i (bits WIDTH-1-2i and WIDTH-2-2i) is on `d_rise`/`d_fall` during cycle k+1+i, for i = 0..P-1.
- **Throughput.** One word per P cycles when `s_valid` and `enable` stay high.
- **Pin latency.** `out_ddr_flop` adds its own fixed output register latency. The parent applies that same latency to both data and `frame` by passing each through an identical DDR flop instance.
- **Input/output paths.** No combinational path from `s_valid` or `s_data` to any output. `enable` → `s_ready` is the only combinational input-to-output path.

## Structure
- **Shared package** `wave_gen_pkg` holds:
  - the state enum (`IDLE`, `SHIFT`);
  - the localparam for the pair count;
  - the clog2 counter-width function.
- **Single module, no sub-modules.** The `out_ddr_flop` instances live in the parent, so the serializer simulates without vendor primitives.
- **Elaboration-time checks** reject odd WIDTH or WIDTH < 2.

## Test plan
All scenarios use WIDTH=8 and IDLE_BIT=0 unless stated.
- **Single word:** one 0xB4 accepted at edge k → pairs (1,0),(1,1),(0,1),(0,0) in cycles k+1..k+4, `frame` high only at k+1, `underrun` pulse at k+5, outputs 0 from k+5.
- **Back-to-back stream:** 0xFF, 0x00, 0xA5 with `s_valid` held high → `s_ready` high every 4th cycle, 12 contiguous pairs, `frame` at k+1, k+5, k+9, one `underrun` after the last word.
- **Backpressure/enable:** drop `enable` during pair 1 of 0x3C → word completes, `s_ready` stays 0, next word held off until `enable` returns, `underrun` pulses once.
- **Reset mid-word:** `rst` during pair 2 of 0xC3 → next cycle `busy=0`, `d_rise=d_fall=0`, `frame=0`, no `underrun` pulse; a word presented together with `rst` is not accepted.
- **WIDTH=2, IDLE_BIT=1:** words 2'b10, 2'b01 back-to-back → (1,0),(0,1) on consecutive cycles, `frame` high both cycles, idle outputs 1 before and after.
- **Random stream:** random `s_valid`/`enable` against a scoreboard model → reconstructed word sequence matches the accepted sequence, and every stream gap yields exactly one `underrun` pulse.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared types and helpers for the wave generator output path.
// State encoding, pair-count helpers and counter sizing.
package wave_gen_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_PAIRS = DEF_WIDTH / 2;

   function automatic int pair_count(input int width);
      return width / 2;
   endfunction

   // Never narrower than one bit, so P=1 still gets a real counter.
   function automatic int cnt_width(input int pairs);
      int w;
      w = 1;
      while ((1 << w) < pairs) w++;
      return w;
   endfunction

endpackage

// File: rtl/ddr_tx_serializer.sv
// Word-to-DDR-pair serializer feeding the out_ddr_flop pins.
// Streams MSB-first pairs, gapless when fed, idles at IDLE_BIT.
module ddr_tx_serializer
   import wave_gen_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             d_rise,
   output logic             d_fall,
   output logic             frame,
   output logic             busy,
   output logic             underrun
);

   localparam int P  = pair_count(WIDTH);
   localparam int CW = cnt_width(P);
   localparam logic [CW-1:0] LAST = CW'(P - 1);

   if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_width_check
      $error("ddr_tx_serializer: WIDTH must be even and >= 2");
   end

   ser_state_t       state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             accept;

   // Ready ahead of the last pair lets the next word follow with no gap.
   assign s_ready = enable && ((state == IDLE) || (cnt == LAST));
   assign accept  = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sr       <= '0;
         cnt      <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  sr    <= s_data;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt != LAST) begin
                  sr  <= sr << 2;
                  cnt <= cnt + CW'(1);
               end else if (accept) begin
                  sr  <= s_data;
                  cnt <= '0;
               end else begin
                  state    <= IDLE;
                  cnt      <= '0;
                  underrun <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy   = (state == SHIFT);
   assign d_rise = busy ? sr[WIDTH-1] : IDLE_BIT;
   assign d_fall = busy ? sr[WIDTH-2] : IDLE_BIT;
   assign frame  = busy && (cnt == '0);

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Directed vector table plus a random scoreboard run for
// ddr_tx_serializer at WIDTH=8 and WIDTH=2/IDLE_BIT=1.
module tb_ddr_tx_serializer;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready, d_rise, d_fall, frame, busy, underrun;
   logic [1:0] s_data2;
   logic       s_valid2;
   logic       s_ready2, d_rise2, d_fall2, frame2, busy2, underrun2;

   int nvec;
   int nerr;

   ddr_tx_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .d_rise(d_rise), .d_fall(d_fall), .frame(frame),
      .busy(busy), .underrun(underrun)
   );

   ddr_tx_serializer #(.WIDTH(2), .IDLE_BIT(1'b1)) dut2 (
      .clk(clk), .rst(rst), .enable(enable),
      .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
      .d_rise(d_rise2), .d_fall(d_fall2), .frame(frame2),
      .busy(busy2), .underrun(underrun2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // exp/act packing: {s_ready, d_rise, d_fall, frame, busy, underrun}
   typedef struct {
      logic       r;
      logic       e;
      logic       v;
      logic       w2;
      logic       chk;
      logic [7:0] d;
      logic [5:0] x;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, e, v, w2, chk,
                      input logic [7:0] d, input logic [5:0] x);
      vec_t t;
      t.r = r; t.e = e; t.v = v; t.w2 = w2; t.chk = chk;
      t.d = d; t.x = x;
      tv.push_back(t);
   endtask

   task automatic check(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   localparam int P = 4;
   int         rem;
   logic       ur_exp;
   logic       rdy_m;
   logic       acc;
   logic [7:0] word;
   logic [7:0] accq[$];
   logic [5:0] act;

   initial begin
      nvec = 0; nerr = 0;
      rst = 1'b1; enable = 1'b1;
      s_valid = 1'b0; s_data = '0;
      s_valid2 = 1'b0; s_data2 = '0;

      // single word 0xB4
      add(1,1,0,0,0,8'h00,6'b000000);
      add(0,1,1,0,1,8'hB4,6'b100000);
      add(0,1,0,0,1,8'h00,6'b010110);
      add(0,1,0,0,1,8'h00,6'b011010);
      add(0,1,0,0,1,8'h00,6'b001010);
      add(0,1,0,0,1,8'h00,6'b100010);
      add(0,1,0,0,1,8'h00,6'b100001);
      add(0,1,0,0,1,8'h00,6'b100000);
      // back-to-back FF, 00, A5
      add(0,1,1,0,1,8'hFF,6'b100000);
      add(0,1,1,0,1,8'h00,6'b011110);
      add(0,1,1,0,1,8'h00,6'b011010);
      add(0,1,1,0,1,8'h00,6'b011010);
      add(0,1,1,0,1,8'h00,6'b111010);
      add(0,1,1,0,1,8'hA5,6'b000110);
      add(0,1,1,0,1,8'hA5,6'b000010);
      add(0,1,1,0,1,8'hA5,6'b000010);
      add(0,1,1,0,1,8'hA5,6'b100010);
      add(0,1,0,0,1,8'h00,6'b010110);
      add(0,1,0,0,1,8'h00,6'b010010);
      add(0,1,0,0,1,8'h00,6'b001010);
      add(0,1,0,0,1,8'h00,6'b101010);
      add(0,1,0,0,1,8'h00,6'b100001);
      // enable dropped during pair 1 of 0x3C
      add(0,1,1,0,1,8'h3C,6'b100000);
      add(0,1,1,0,1,8'h81,6'b000110);
      add(0,0,1,0,1,8'h81,6'b011010);
      add(0,0,1,0,1,8'h81,6'b011010);
      add(0,0,1,0,1,8'h81,6'b000010);
      add(0,0,1,0,1,8'h81,6'b000001);
      add(0,0,1,0,1,8'h81,6'b000000);
      add(0,1,1,0,1,8'h81,6'b100000);
      add(0,1,0,0,1,8'h00,6'b010110);
      add(0,1,0,0,1,8'h00,6'b000010);
      add(0,1,0,0,1,8'h00,6'b000010);
      add(0,1,0,0,1,8'h00,6'b101010);
      add(0,1,0,0,1,8'h00,6'b100001);
      // reset during pair 2 of 0xC3, then reset beats accept
      add(0,1,1,0,1,8'hC3,6'b100000);
      add(0,1,0,0,1,8'h00,6'b011110);
      add(0,1,0,0,1,8'h00,6'b000010);
      add(1,1,1,0,1,8'h55,6'b000010);
      add(0,1,0,0,1,8'h00,6'b100000);
      add(1,1,1,0,1,8'hFF,6'b100000);
      add(0,1,0,0,1,8'h00,6'b100000);
      add(0,1,0,0,1,8'h00,6'b100000);
      // WIDTH=2, IDLE_BIT=1: 2'b10 then 2'b01
      add(0,1,1,1,1,8'h02,6'b111000);
      add(0,1,1,1,1,8'h01,6'b110110);
      add(0,1,0,1,1,8'h00,6'b101110);
      add(0,1,0,1,1,8'h00,6'b111001);
      add(0,1,0,1,1,8'h00,6'b111000);

      @(posedge clk); #1;
      foreach (tv[i]) begin
         rst = tv[i].r;
         enable = tv[i].e;
         if (tv[i].w2) begin
            s_valid2 = tv[i].v; s_data2 = tv[i].d[1:0];
            s_valid = 1'b0; s_data = '0;
         end else begin
            s_valid = tv[i].v; s_data = tv[i].d;
            s_valid2 = 1'b0; s_data2 = '0;
         end
         #1;
         if (tv[i].w2)
            act = {s_ready2, d_rise2, d_fall2, frame2, busy2, underrun2};
         else
            act = {s_ready, d_rise, d_fall, frame, busy, underrun};
         if (tv[i].chk)
            check($sformatf("vec%0d", i), {2'b00, act}, {2'b00, tv[i].x});
         @(posedge clk); #1;
      end

      // random stream against a remaining-pairs scoreboard
      rst = 1'b0; s_valid2 = 1'b0;
      rem = 0; ur_exp = 1'b0; word = '0;
      for (int c = 0; c < 400; c++) begin
         enable  = (c < 390) ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_valid = (c < 390) ? ($urandom_range(0, 2) != 0) : 1'b0;
         s_data  = 8'($urandom_range(0, 255));
         #1;
         rdy_m = enable && (rem <= 1);
         check("rand_ready", {7'd0, s_ready}, {7'd0, rdy_m});
         check("rand_ctl", {5'd0, busy, frame, underrun},
               {5'd0, rem > 0, rem == P, ur_exp});
         if (rem > 0) begin
            word = {word[5:0], d_rise, d_fall};
            if (rem == 1) begin
               if (accq.size() == 0) begin
                  nvec++; nerr++;
                  $display("FAIL rand_word: got %h want none", word);
               end else begin
                  check("rand_word", word, accq.pop_front());
               end
            end
         end else begin
            check("rand_idle", {6'd0, d_rise, d_fall}, 8'd0);
         end
         acc = s_valid && rdy_m;
         if (acc) accq.push_back(s_data);
         ur_exp = (rem == 1) && !acc;
         rem = acc ? P : ((rem > 0) ? rem - 1 : 0);
         @(posedge clk); #1;
      end
      check("rand_leftover", 8'(accq.size()), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
